// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_pkg: shared widths, register typedefs and writeback source encoding
//   DEFAULT_ADDRESS_WIDTH / DEFAULT_DATA_WIDTH : default register address / data widths
//   reg_addr_t / reg_data_t                    : register address / data types at default widths
//   src_e                                      : writeback source (ALU or LSU), used for round-robin state
package regfile_pkg;
   localparam int DEFAULT_ADDRESS_WIDTH = 5;
   localparam int DEFAULT_DATA_WIDTH = 32;
   typedef logic [DEFAULT_ADDRESS_WIDTH-1:0] reg_addr_t;
   typedef logic [DEFAULT_DATA_WIDTH-1:0] reg_data_t;
   typedef enum logic {SRC_ALU, SRC_LSU} src_e;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback, issue, hazard-check and register-file write bundle
//   alu_* / lsu_*      : valid/ready writeback requests with destination and data
//   iss_valid/iss_rd   : destination of the issuing instruction (scoreboard set)
//   chk_rs1/chk_rs2    : decode source addresses; hzd_rs1/hzd_rs2 flag outstanding writes
//   AD3/WE3/WD3        : register-file write port; pending is the scoreboard bitmap
//   modport master     : requesters, issue and decode side
//   modport slave      : the arbiter
interface regfile_wb_arbiter_if import regfile_pkg::*; #(
   parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
   logic alu_valid, alu_ready;
   logic [ADDRESS_WIDTH-1:0] alu_rd;
   logic [DATA_WIDTH-1:0] alu_data;
   logic lsu_valid, lsu_ready;
   logic [ADDRESS_WIDTH-1:0] lsu_rd;
   logic [DATA_WIDTH-1:0] lsu_data;
   logic iss_valid;
   logic [ADDRESS_WIDTH-1:0] iss_rd;
   logic [ADDRESS_WIDTH-1:0] chk_rs1, chk_rs2;
   logic hzd_rs1, hzd_rs2;
   logic [ADDRESS_WIDTH-1:0] AD3;
   logic WE3;
   logic [DATA_WIDTH-1:0] WD3;
   logic [2**ADDRESS_WIDTH-1:0] pending;
   modport master (
      output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
      output iss_valid, iss_rd, chk_rs1, chk_rs2,
      input alu_ready, lsu_ready, hzd_rs1, hzd_rs2, AD3, WE3, WD3, pending
   );
   modport slave (
      input alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
      input iss_valid, iss_rd, chk_rs1, chk_rs2,
      output alu_ready, lsu_ready, hzd_rs1, hzd_rs2, AD3, WE3, WD3, pending
   );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : requests, bit 0 = ALU, bit 1 = LSU
//   accept     : a granted request transferred this cycle
//   gnt[1:0]   : one-hot combinational grant, never set without its request
module rr_arb2 import regfile_pkg::*; (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt
);
   src_e last_grant;
   // On a tie the source that did not win last time is granted.
   always_comb gnt = &req ? (last_grant == SRC_LSU ? 2'b01 : 2'b10) : req;
   // Reset to LSU so the ALU wins the first tie.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) last_grant <= SRC_LSU;
      else if (accept) last_grant <= gnt[1] ? SRC_LSU : SRC_ALU;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between ALU and LSU writeback
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of regfile_wb_arbiter_if (requests, issue, hazard checks,
//                registered AD3/WE3/WD3 write port and pending scoreboard)
module regfile_wb_arbiter import regfile_pkg::*; #(
   parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input logic clk,
   input logic rst_n,
   regfile_wb_arbiter_if.slave bus
);
   localparam int NR = 2**ADDRESS_WIDTH;
   logic [1:0] gnt;
   logic accept, load, we;
   logic [ADDRESS_WIDTH-1:0] sel_rd, ad;
   logic [DATA_WIDTH-1:0] sel_data, wd;
   logic [NR-1:0] pend, set_mask, clr_mask;
   rr_arb2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    ({bus.lsu_valid, bus.alu_valid}),
      .accept (accept),
      .gnt    (gnt)
   );
   always_comb begin
      accept = |gnt;
      sel_rd = gnt[1] ? bus.lsu_rd : bus.alu_rd;
      sel_data = gnt[1] ? bus.lsu_data : bus.alu_data;
      // Writes to x0 complete the handshake but never reach the register file.
      load = accept && sel_rd != '0;
      set_mask = (bus.iss_valid && bus.iss_rd != '0) ? NR'(1) << bus.iss_rd : '0;
      clr_mask = we ? NR'(1) << ad : '0;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         we <= 1'b0;
         ad <= '0;
         wd <= '0;
         pend <= '0;
      end else begin
         we <= load;
         if (load) begin
            ad <= sel_rd;
            wd <= sel_data;
         end
         // Clear lands with the register-file write; a same-edge issue re-sets the bit.
         pend <= (pend & ~clr_mask) | set_mask;
      end
   assign bus.alu_ready = gnt[0];
   assign bus.lsu_ready = gnt[1];
   assign bus.AD3 = ad;
   assign bus.WE3 = we;
   assign bus.WD3 = wd;
   assign bus.pending = pend;
   assign bus.hzd_rs1 = bus.chk_rs1 != '0 && pend[bus.chk_rs1];
   assign bus.hzd_rs2 = bus.chk_rs2 != '0 && pend[bus.chk_rs2];
endmodule
